// File: rtl/mpc_debug_cross_halt_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mpc_debug_cross_halt_ctrl
// Purpose  : Coordinates a debug halt across the platform's CPU cores. When
//            the first participating core enters debug mode, every other
//            participating core gets a break request. The block then waits
//            for all participants to acknowledge, reports all_halted, and
//            re-arms once every participant has been resumed.
// Ports    : clk, reset          - system clock, async active-high reset
//            debugack[N]         - per-core debug acknowledge (clk domain)
//            sync_en[N]          - per-core participation mask
//            break_req[N]        - per-core break request (level)
//            all_halted          - every participant is halted
//            halt_timeout        - sticky; an episode timed out
//            timeout_clr         - pulse; clears halt_timeout
//            trigger_core        - core that started the last episode
//            busy, state_o       - episode in progress / current state
// Options  : MPC_DEBUG_HALT_STATS_EN adds halt_count and last_halt_latency.
// Revision : 1.0 - initial release
// ============================================================================
module mpc_debug_cross_halt_ctrl #(
  parameter int NUM_CORES      = 6,
  parameter int IDX_W          = 3,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_CORES-1:0] debugack,
  input  logic [NUM_CORES-1:0] sync_en,
  output logic [NUM_CORES-1:0] break_req,
  output logic                 all_halted,
  output logic                 halt_timeout,
  input  logic                 timeout_clr,
  output logic [IDX_W-1:0]     trigger_core,
  output logic                 busy,
  output logic [1:0]           state_o
`ifdef MPC_DEBUG_HALT_STATS_EN
  ,
  output logic [15:0]          halt_count,
  output logic [15:0]          last_halt_latency
`endif
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_HALTING  = 2'd1,
    ST_HALTED   = 2'd2,
    ST_RESUMING = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic [NUM_CORES-1:0] debugack_q;
  logic [NUM_CORES-1:0] active_mask_q, active_mask_d;
  logic [NUM_CORES-1:0] break_req_q, break_req_d;
  logic [CNT_W-1:0]     counter_q, counter_d;
  logic                 all_halted_q, all_halted_d;
  logic                 halt_timeout_q, halt_timeout_d;
  logic [IDX_W-1:0]     trigger_core_q, trigger_core_d;

  logic [NUM_CORES-1:0] rise;
  logic [NUM_CORES-1:0] fall;
  logic [IDX_W-1:0]     rise_lowest;
  logic                 all_acked;
  logic                 halt_exit;

  assign rise      = debugack & ~debugack_q & sync_en;
  // Falls are only meaningful for cores captured into the current episode.
  assign fall      = ~debugack & debugack_q & active_mask_q;
  assign all_acked = ((debugack & active_mask_q) == active_mask_q);

  // Priority encoder: scanning downwards leaves the lowest set index.
  always_comb begin
    rise_lowest = '0;
    for (int i = NUM_CORES - 1; i >= 0; i--) begin
      if (rise[i]) rise_lowest = IDX_W'(i);
    end
  end

  always_comb begin
    state_d        = state_q;
    active_mask_d  = active_mask_q;
    break_req_d    = break_req_q;
    counter_d      = counter_q;
    all_halted_d   = all_halted_q;
    halt_timeout_d = halt_timeout_q;
    trigger_core_d = trigger_core_q;
    halt_exit      = 1'b0;

    if (timeout_clr) halt_timeout_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (rise != '0) begin
          state_d        = ST_HALTING;
          active_mask_d  = sync_en;
          trigger_core_d = rise_lowest;
          counter_d      = '0;
          // sync_en is the mask being captured at this same edge.
          break_req_d    = sync_en & ~debugack;
        end
      end
      ST_HALTING: begin
        // A request drops once its core acks and is never re-raised.
        break_req_d = break_req_q & ~debugack;
        if (all_acked) begin
          state_d      = ST_HALTED;
          all_halted_d = 1'b1;
          break_req_d  = '0;
          halt_exit    = 1'b1;
        end else if (counter_q == CNT_LAST) begin
          state_d        = ST_HALTED;
          all_halted_d   = 1'b0;
          halt_timeout_d = 1'b1;  // set overrides a same-cycle clear
          break_req_d    = '0;
          halt_exit      = 1'b1;
        end else begin
          counter_d = counter_q + 1'b1;
        end
      end
      ST_HALTED: begin
        if (fall != '0) begin
          state_d      = ST_RESUMING;
          all_halted_d = 1'b0;
        end
      end
      ST_RESUMING: begin
        // Re-entering debug here is waited out; no new episode starts.
        if ((debugack & active_mask_q) == '0) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      debugack_q     <= '0;
      active_mask_q  <= '0;
      break_req_q    <= '0;
      counter_q      <= '0;
      all_halted_q   <= 1'b0;
      halt_timeout_q <= 1'b0;
      trigger_core_q <= '0;
    end else begin
      state_q        <= state_d;
      debugack_q     <= debugack;
      active_mask_q  <= active_mask_d;
      break_req_q    <= break_req_d;
      counter_q      <= counter_d;
      all_halted_q   <= all_halted_d;
      halt_timeout_q <= halt_timeout_d;
      trigger_core_q <= trigger_core_d;
    end
  end

  assign break_req    = break_req_q;
  assign all_halted   = all_halted_q;
  assign halt_timeout = halt_timeout_q;
  assign trigger_core = trigger_core_q;
  assign busy         = (state_q != ST_IDLE);
  assign state_o      = state_q;

`ifdef MPC_DEBUG_HALT_STATS_EN
  logic [15:0] halt_count_q, halt_count_d;
  logic [15:0] last_halt_latency_q, last_halt_latency_d;

  always_comb begin
    halt_count_d        = halt_count_q;
    last_halt_latency_d = last_halt_latency_q;
    if (halt_exit) begin
      if (halt_count_q != 16'hFFFF) halt_count_d = halt_count_q + 16'd1;
      last_halt_latency_d = 16'(counter_q);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      halt_count_q        <= '0;
      last_halt_latency_q <= '0;
    end else begin
      halt_count_q        <= halt_count_d;
      last_halt_latency_q <= last_halt_latency_d;
    end
  end

  assign halt_count        = halt_count_q;
  assign last_halt_latency = last_halt_latency_q;
`else
  // Without the statistics outputs the exit strobe has no consumer.
  logic unused_halt_exit;
  assign unused_halt_exit = halt_exit;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mpc_debug_cross_halt_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_mpc_debug_cross_halt_ctrl
// Purpose  : Directed, table-driven bench for mpc_debug_cross_halt_ctrl with
//            hand-written sequences for timeout and asynchronous reset.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mpc_debug_cross_halt_ctrl;

  logic       clk;
  logic       reset;
  logic [5:0] debugack;
  logic [5:0] sync_en;
  logic [5:0] break_req;
  logic       all_halted;
  logic       halt_timeout;
  logic       timeout_clr;
  logic [2:0] trigger_core;
  logic       busy;
  logic [1:0] state_o;
`ifdef MPC_DEBUG_HALT_STATS_EN
  logic [15:0] halt_count;
  logic [15:0] last_halt_latency;
`endif

  mpc_debug_cross_halt_ctrl #(
    .NUM_CORES      (6),
    .IDX_W          (3),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .debugack     (debugack),
    .sync_en      (sync_en),
    .break_req    (break_req),
    .all_halted   (all_halted),
    .halt_timeout (halt_timeout),
    .timeout_clr  (timeout_clr),
    .trigger_core (trigger_core),
    .busy         (busy),
    .state_o      (state_o)
`ifdef MPC_DEBUG_HALT_STATS_EN
    ,
    .halt_count        (halt_count),
    .last_halt_latency (last_halt_latency)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [5:0] ack;
    logic [5:0] en;
    logic [5:0] br;
    logic       ah;
    logic [2:0] trig;
    logic [1:0] st;
  } vec_t;

  vec_t vecs [31];
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Drive inputs on the falling edge, then sample 1 ns after the rising edge.
  task automatic cyc(input logic [5:0] ack, input logic [5:0] en, input logic clr);
    @(negedge clk);
    debugack    = ack;
    sync_en     = en;
    timeout_clr = clr;
    @(posedge clk);
    #1;
  endtask

  initial begin
    //            ack    en     br     ah    trig  st
    vecs[0]  = '{6'h00, 6'h3F, 6'h00, 1'b0, 3'd0, 2'd0};
    // core 2 triggers, others ack one by one
    vecs[1]  = '{6'h04, 6'h3F, 6'h3B, 1'b0, 3'd2, 2'd1};
    vecs[2]  = '{6'h05, 6'h3F, 6'h3A, 1'b0, 3'd2, 2'd1};
    vecs[3]  = '{6'h0D, 6'h3F, 6'h32, 1'b0, 3'd2, 2'd1};
    vecs[4]  = '{6'h2D, 6'h3F, 6'h12, 1'b0, 3'd2, 2'd1};
    vecs[5]  = '{6'h3D, 6'h3F, 6'h02, 1'b0, 3'd2, 2'd1};
    vecs[6]  = '{6'h3F, 6'h3F, 6'h00, 1'b1, 3'd2, 2'd2};
    vecs[7]  = '{6'h3F, 6'h3F, 6'h00, 1'b1, 3'd2, 2'd2};
    // resume: core 0 drops, re-raises (no new episode), then all drop
    vecs[8]  = '{6'h3E, 6'h3F, 6'h00, 1'b0, 3'd2, 2'd3};
    vecs[9]  = '{6'h3F, 6'h3F, 6'h00, 1'b0, 3'd2, 2'd3};
    vecs[10] = '{6'h00, 6'h3F, 6'h00, 1'b0, 3'd2, 2'd0};
    vecs[11] = '{6'h00, 6'h3F, 6'h00, 1'b0, 3'd2, 2'd0};
    // cores 4 and 1 together; core 5 rises mid-episode
    vecs[12] = '{6'h12, 6'h3F, 6'h2D, 1'b0, 3'd1, 2'd1};
    vecs[13] = '{6'h32, 6'h3F, 6'h0D, 1'b0, 3'd1, 2'd1};
    vecs[14] = '{6'h3F, 6'h3F, 6'h00, 1'b1, 3'd1, 2'd2};
    vecs[15] = '{6'h00, 6'h3F, 6'h00, 1'b0, 3'd1, 2'd3};
    vecs[16] = '{6'h00, 6'h3F, 6'h00, 1'b0, 3'd1, 2'd0};
    // sync_en=05: core 1 ignored, core 0 triggers, core 2 completes
    vecs[17] = '{6'h02, 6'h05, 6'h00, 1'b0, 3'd1, 2'd0};
    vecs[18] = '{6'h03, 6'h05, 6'h04, 1'b0, 3'd0, 2'd1};
    vecs[19] = '{6'h03, 6'h05, 6'h04, 1'b0, 3'd0, 2'd1};
    vecs[20] = '{6'h07, 6'h05, 6'h00, 1'b1, 3'd0, 2'd2};
    vecs[21] = '{6'h02, 6'h05, 6'h00, 1'b0, 3'd0, 2'd3};
    vecs[22] = '{6'h02, 6'h05, 6'h00, 1'b0, 3'd0, 2'd0};
    // single participant
    vecs[23] = '{6'h03, 6'h01, 6'h00, 1'b0, 3'd0, 2'd1};
    vecs[24] = '{6'h03, 6'h01, 6'h00, 1'b1, 3'd0, 2'd2};
    vecs[25] = '{6'h00, 6'h01, 6'h00, 1'b0, 3'd0, 2'd3};
    vecs[26] = '{6'h00, 6'h01, 6'h00, 1'b0, 3'd0, 2'd0};
    // sync_en=0: never leaves IDLE
    vecs[27] = '{6'h3F, 6'h00, 6'h00, 1'b0, 3'd0, 2'd0};
    vecs[28] = '{6'h00, 6'h00, 6'h00, 1'b0, 3'd0, 2'd0};
    vecs[29] = '{6'h3F, 6'h00, 6'h00, 1'b0, 3'd0, 2'd0};
    vecs[30] = '{6'h00, 6'h3F, 6'h00, 1'b0, 3'd0, 2'd0};

    reset       = 1'b1;
    debugack    = '0;
    sync_en     = '0;
    timeout_clr = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_state", int'(state_o), 0);
    chk("rst_br", int'(break_req), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_to", int'(halt_timeout), 0);
`ifdef MPC_DEBUG_HALT_STATS_EN
    chk("rst_count", int'(halt_count), 0);
`endif
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 31; i++) begin
      cyc(vecs[i].ack, vecs[i].en, 1'b0);
      chk($sformatf("v%0d_br", i), int'(break_req), int'(vecs[i].br));
      chk($sformatf("v%0d_ah", i), int'(all_halted), int'(vecs[i].ah));
      chk($sformatf("v%0d_trig", i), int'(trigger_core), int'(vecs[i].trig));
      chk($sformatf("v%0d_state", i), int'(state_o), int'(vecs[i].st));
      chk($sformatf("v%0d_busy", i), int'(busy), (vecs[i].st != 2'd0) ? 1 : 0);
      chk($sformatf("v%0d_to", i), int'(halt_timeout), 0);
`ifdef MPC_DEBUG_HALT_STATS_EN
      // core 5's rise in cycle 13 must not have restarted the counter
      if (i == 14) chk("v14_latency", int'(last_halt_latency), 1);
`endif
    end
`ifdef MPC_DEBUG_HALT_STATS_EN
    chk("table_count", int'(halt_count), 4);
`endif

    // Timeout: cores 0 and 3 participate, core 3 never acks. sync_en is
    // narrowed after capture, which must not shorten the episode.
    cyc(6'h01, 6'h09, 1'b0);
    chk("to_enter_state", int'(state_o), 1);
    chk("to_enter_br", int'(break_req), 8);
    for (int k = 1; k < 16; k++) begin
      cyc(6'h01, 6'h01, 1'b0);
      chk($sformatf("to_wait%0d_state", k), int'(state_o), 1);
      chk($sformatf("to_wait%0d_to", k), int'(halt_timeout), 0);
    end
    chk("to_wait_br", int'(break_req), 8);
    // clear requested in the timeout cycle itself: the set must win
    cyc(6'h01, 6'h01, 1'b1);
    chk("to_hit_to", int'(halt_timeout), 1);
    chk("to_hit_state", int'(state_o), 2);
    chk("to_hit_ah", int'(all_halted), 0);
    chk("to_hit_br", int'(break_req), 0);
`ifdef MPC_DEBUG_HALT_STATS_EN
    chk("to_latency", int'(last_halt_latency), 15);
    chk("to_count", int'(halt_count), 5);
`endif
    cyc(6'h01, 6'h01, 1'b1);
    chk("to_clr_to", int'(halt_timeout), 0);
    chk("to_clr_state", int'(state_o), 2);
    cyc(6'h00, 6'h01, 1'b0);
    chk("to_resume_state", int'(state_o), 3);
    cyc(6'h00, 6'h01, 1'b0);
    chk("to_idle_state", int'(state_o), 0);

    // Asynchronous reset in the middle of HALTING.
    cyc(6'h04, 6'h3F, 1'b0);
    chk("ar_pre_br", int'(break_req), 'h3B);
    chk("ar_pre_busy", int'(busy), 1);
    #2;
    reset = 1'b1;
    #1;
    chk("ar_br", int'(break_req), 0);
    chk("ar_busy", int'(busy), 0);
    chk("ar_ah", int'(all_halted), 0);
    chk("ar_state", int'(state_o), 0);
    chk("ar_trig", int'(trigger_core), 0);
`ifdef MPC_DEBUG_HALT_STATS_EN
    chk("ar_count", int'(halt_count), 0);
`endif
    @(negedge clk);
    debugack = '0;
    reset    = 1'b0;
    cyc(6'h00, 6'h01, 1'b0);
    cyc(6'h01, 6'h01, 1'b0);
    chk("post_state1", int'(state_o), 1);
    cyc(6'h01, 6'h01, 1'b0);
    chk("post_state2", int'(state_o), 2);
    chk("post_ah", int'(all_halted), 1);
`ifdef MPC_DEBUG_HALT_STATS_EN
    chk("post_count", int'(halt_count), 1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mpc_debug_cross_halt_ctrl.md
Name: mpc_debug_cross_halt_ctrl

Overview:
- System-clock controller that sequences a coordinated debug halt across all CPU cores' JTAG debug modules on the multicore platform.
- When any participating core enters debug mode (its debugack rises), the block drives a debug break request into every other participating core.
- It waits until every participating core acknowledges, then reports an all-halted status to the host-visible control/status register.
- It re-arms once all participating cores have been resumed through JTAG.

Parameters:
- NUM_CORES, 6, number of CPU cores and debug modules served.
- IDX_W, 3, width of the core index; must be at least clog2(NUM_CORES).
- TIMEOUT_CYCLES, 1024, maximum clk cycles to wait for all participants to acknowledge a break; legal range 2..65535.

Ports:
- clk  in  1  system clock; same domain as each debug module's sysclk side.
- reset  in  1  asynchronous, active-high reset.
- debugack  in  NUM_CORES  per-core debug acknowledge, already synchronous to clk.
- sync_en  in  NUM_CORES  per-core participation mask from the control register.
- break_req  out  NUM_CORES  per-core debug break request, level; held until that core acknowledges.
- all_halted  out  1  every participating core is in debug mode.
- halt_timeout  out  1  sticky; a halt episode timed out.
- timeout_clr  in  1  single-cycle pulse; clears halt_timeout.
- trigger_core  out  IDX_W  index of the core that started the last episode.
- busy  out  1  an episode is in progress (state != IDLE).
- state_o  out  2  current state: 0 IDLE, 1 HALTING, 2 HALTED, 3 RESUMING.

Behaviour:
- Reset, asynchronous and immediate: state IDLE; all outputs 0; internal registers cleared (debugack_q, active_mask, counter).
- Edge detect: rise = debugack & ~debugack_q & sync_en; debugack_q is registered every cycle.
- IDLE
  - If rise != 0: capture active_mask <= sync_en and trigger_core <= lowest set index in rise. Go to HALTING with counter 0.
  - break_req <= active_mask & ~debugack. This takes effect at the same edge, so break_req rises one clk after debugack rises.
- HALTING
  - break_req[i] is cleared in the cycle after debugack[i] is seen high. It is never re-asserted within the episode.
  - If (debugack & active_mask) == active_mask: go to HALTED, set all_halted=1, clear break_req.
  - Else if counter == TIMEOUT_CYCLES-1: set halt_timeout=1, clear break_req, go to HALTED with all_halted=0.
  - Otherwise increment counter.
- HALTED
  - all_halted stays 1 while all participants remain halted.
  - Any participant's debugack falling: all_halted <= 0, go to RESUMING.
- RESUMING
  - When (debugack & active_mask) == 0: go to IDLE. Rising edges are evaluated again from the next cycle.
  - Debugack rising again while in RESUMING does not start a new episode. The core is waited out until all participants are low.
- Simultaneous events
  - Multiple rises in one cycle: lowest index wins trigger_core; a single episode is started.
  - Rises outside IDLE never restart or extend an episode.
  - timeout_clr asserted in the same cycle as a timeout: the set wins.
- Masking rules
  - sync_en changes after capture have no effect until the next episode.
  - Cores with sync_en=0 never trigger, never receive break_req and are ignored in the all-halted check.
  - sync_en == 0: the block stays in IDLE permanently.
  - Single participant: HALTING completes the next cycle with no break_req asserted.
- The counter width is clog2(TIMEOUT_CYCLES) and never wraps; it is cleared on entry to HALTING.

Optional Feature:
- Macro: MPC_DEBUG_HALT_STATS_EN.
- Defined: adds two outputs.
  - halt_count out 16: counts completed HALTING->HALTED transitions, including timeouts; saturates at 16'hFFFF.
  - last_halt_latency out 16: counter value captured on HALTING exit.
  - Both outputs reset to 0.
- Undefined: neither port exists, no extra logic is built, and all other behaviour is identical.

Test Plan:
- Core 2 asserts debugack, sync_en=6'h3F: break_req=6'h3B one cycle later. Cores ack over 5 cycles, then all_halted=1, trigger_core=2, state_o=2, break_req=0.
- Cores 4 and 1 rise in the same cycle: trigger_core=1 and break_req=6'h2D. A second rise on core 5 during HALTING does not reset the counter.
- TIMEOUT_CYCLES=16, core 3 never acks: halt_timeout=1 exactly 16 cycles after entering HALTING, state_o=2, all_halted=0. Then timeout_clr clears halt_timeout.
- sync_en=6'h05 with core 1 halting: no episode starts. Core 0 halts: break_req=6'h04 only, then all_halted=1 once core 2 acks.
- Resume sequence: drop core 0 debugack, giving all_halted=0 and state_o=3. Re-raise core 0 before the others drop: no new episode. Drop all: state_o=0, and a subsequent rise starts a new episode.
- Assert reset mid-HALTING: break_req, busy and all_halted go to 0 without waiting for a clock edge. With the stats macro defined, halt_count reads 0 after reset and 1 after one completed episode.
